// File: rtl/loader_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
package loader_pkg;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_valid pulses
// for one cycle after the last byte of each word.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_cnt,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  logic [23:0] partial;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt   <= '0;
      partial    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      byte_cnt   <= '0;
      partial    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    partial[7:0]   <= byte_data;
          2'd1:    partial[15:8]  <= byte_data;
          2'd2:    partial[23:16] <= byte_data;
          default: begin
            word       <= {byte_data, partial};
            word_valid <= 1'b1;
            partial    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding
// the CPU in reset; header is a 16-bit little-endian word count.
//
// state    | meaning
// ST_HDR0  | waiting for count[7:0]
// ST_HDR1  | waiting for count[15:8], then range check
// ST_DATA  | packing program bytes into words and writing them
// ST_DONE  | load complete, CPU released
// ST_ERROR | count exceeded memory depth, CPU held
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t            state, state_nxt;
  logic [7:0]        count_lo;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       hdr;
  logic              accept;
  logic              restart;
  logic              last_byte;
  logic [1:0]        pk_cnt;
  logic [31:0]       pk_word;
  logic              pk_word_valid;

  assign accept    = in_valid & in_ready;
  assign restart   = load_start & ((state == ST_DONE) | (state == ST_ERROR));
  assign hdr       = {in_data, count_lo};
  // idx has already advanced past every earlier word by the time a word's 4th byte arrives
  assign last_byte = (pk_cnt == 2'(WORD_BYTES - 1)) && (idx == last_idx);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HDR0: if (accept) state_nxt = ST_HDR1;
      ST_HDR1: begin
        if (accept) begin
          if (hdr == 16'd0)                 state_nxt = ST_DONE;
          else if ({1'b0, hdr} > MAX_WORDS) state_nxt = ST_ERROR;
          else                              state_nxt = ST_DATA;
        end
      end
      ST_DATA:  if (accept && last_byte) state_nxt = ST_DONE;
      ST_DONE,
      ST_ERROR: if (load_start) state_nxt = ST_HDR0;
      default:  state_nxt = ST_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_HDR0;
      count_lo <= '0;
      last_idx <= '0;
      idx      <= '0;
      in_ready <= 1'b1;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == ST_HDR0) || (state_nxt == ST_HDR1) || (state_nxt == ST_DATA);
      cpu_hold <= (state_nxt != ST_DONE);
      done     <= (state_nxt == ST_DONE);
      err      <= (state_nxt == ST_ERROR);
      if (state == ST_HDR0 && accept) count_lo <= in_data;
      if (state == ST_HDR1 && accept) last_idx <= ADDR_W'(hdr - 16'd1);
      if (restart) begin
        idx      <= '0;
        count_lo <= '0;
        last_idx <= '0;
      end else if (pk_word_valid) begin
        idx <= idx + ADDR_W'(1);
      end
    end
  end

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (accept && (state == ST_DATA)),
    .byte_data  (in_data),
    .byte_cnt   (pk_cnt),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  assign imem_we    = pk_word_valid;
  assign imem_wdata = pk_word;
  assign imem_addr  = idx;

endmodule
